// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between the
// main datapath (requester 0) and the branch/address unit (requester 1).
// Each accepted request runs IDLE -> EXEC -> DONE. An illegal op skips EXEC and
// completes with result 0, carry 0 and err 1.
module alu_share_arbiter #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic [3:0]             op0,
  input  logic [WORD_LENGTH-1:0] a0,
  input  logic [WORD_LENGTH-1:0] b0,
  output logic                   ack0,
  output logic                   done0,
  output logic [WORD_LENGTH-1:0] result0,
  output logic                   carry0,
  output logic                   err0,
  input  logic                   req1,
  input  logic [3:0]             op1,
  input  logic [WORD_LENGTH-1:0] a1,
  input  logic [WORD_LENGTH-1:0] b1,
  output logic                   ack1,
  output logic                   done1,
  output logic [WORD_LENGTH-1:0] result1,
  output logic                   carry1,
  output logic                   err1,
  output logic [WORD_LENGTH-1:0] alu_dataA,
  output logic [WORD_LENGTH-1:0] alu_dataB,
  output logic [3:0]             alu_control,
  input  logic [WORD_LENGTH-1:0] alu_dataC,
  input  logic                   alu_carry,
  output logic                   busy,
  output logic                   grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] OP_IDLE     = 4'b1111;
  localparam logic [3:0] OP_LAST_LEG = 4'b1010;

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   last_grant_r;
  logic                   grant_id_r;
  logic [3:0]             op_r;
  logic [WORD_LENGTH-1:0] a_r;
  logic [WORD_LENGTH-1:0] b_r;
  logic [WORD_LENGTH-1:0] result0_r;
  logic [WORD_LENGTH-1:0] result1_r;
  logic                   carry0_r;
  logic                   carry1_r;
  logic                   err0_r;
  logic                   err1_r;

  logic                   grant_vld_s;
  logic                   grant_sel_s;
  logic [3:0]             sel_op_s;
  logic [WORD_LENGTH-1:0] sel_a_s;
  logic [WORD_LENGTH-1:0] sel_b_s;
  logic                   sel_legal_s;

  // Arbitration in IDLE: a lone requester wins, a tie goes to the one not served last.
  // Held off while reset is asserted so no ack can appear during reset.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_sel_s = 1'b0;
    if ((state_r == ST_IDLE) && reset) begin
      case ({req1, req0})
        2'b01:   begin grant_vld_s = 1'b1; grant_sel_s = 1'b0;          end
        2'b10:   begin grant_vld_s = 1'b1; grant_sel_s = 1'b1;          end
        2'b11:   begin grant_vld_s = 1'b1; grant_sel_s = ~last_grant_r; end
        default: begin grant_vld_s = 1'b0; grant_sel_s = 1'b0;          end
      endcase
    end else begin
      grant_vld_s = 1'b0;
      grant_sel_s = 1'b0;
    end
  end

  // Operand mux for the winning requester, plus the legality check of its op.
  always_comb begin
    sel_op_s = op0;
    sel_a_s  = a0;
    sel_b_s  = b0;
    if (grant_sel_s) begin
      sel_op_s = op1;
      sel_a_s  = a1;
      sel_b_s  = b1;
    end else begin
      sel_op_s = op0;
      sel_a_s  = a0;
      sel_b_s  = b0;
    end
    sel_legal_s = (sel_op_s <= OP_LAST_LEG);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: an illegal op skips EXEC and completes straight away.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_vld_s) begin
          if (sel_legal_s) begin
            state_next_s = ST_EXEC;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state: ack/done pulses, busy, and the ALU pins.
  // The ALU sees the latched operands only in EXEC and is idle otherwise.
  always_comb begin
    ack0        = grant_vld_s & ~grant_sel_s;
    ack1        = grant_vld_s & grant_sel_s;
    done0       = (state_r == ST_DONE) & ~grant_id_r;
    done1       = (state_r == ST_DONE) & grant_id_r;
    busy        = (state_r != ST_IDLE);
    alu_dataA   = '0;
    alu_dataB   = '0;
    alu_control = OP_IDLE;
    if (state_r == ST_EXEC) begin
      alu_dataA   = a_r;
      alu_dataB   = b_r;
      alu_control = op_r;
    end else begin
      alu_dataA   = '0;
      alu_dataB   = '0;
      alu_control = OP_IDLE;
    end
  end

  // Transaction registers: operands latched on grant, and the owner's result
  // written on the edge that enters DONE. The other requester's result is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
      op_r         <= OP_IDLE;
      a_r          <= '0;
      b_r          <= '0;
      result0_r    <= '0;
      result1_r    <= '0;
      carry0_r     <= 1'b0;
      carry1_r     <= 1'b0;
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
    end else begin
      if (grant_vld_s) begin
        op_r         <= sel_op_s;
        a_r          <= sel_a_s;
        b_r          <= sel_b_s;
        grant_id_r   <= grant_sel_s;
        last_grant_r <= grant_sel_s;
        if (!sel_legal_s) begin
          if (grant_sel_s) begin
            result1_r <= '0;
            carry1_r  <= 1'b0;
            err1_r    <= 1'b1;
          end else begin
            result0_r <= '0;
            carry0_r  <= 1'b0;
            err0_r    <= 1'b1;
          end
        end
      end
      if (state_r == ST_EXEC) begin
        if (grant_id_r) begin
          result1_r <= alu_dataC;
          carry1_r  <= alu_carry;
          err1_r    <= 1'b0;
        end else begin
          result0_r <= alu_dataC;
          carry0_r  <= alu_carry;
          err0_r    <= 1'b0;
        end
      end
    end
  end

  assign result0  = result0_r;
  assign carry0   = carry0_r;
  assign err0     = err0_r;
  assign result1  = result1_r;
  assign carry1   = carry1_r;
  assign err1     = err1_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a behavioural ALU drives alu_dataC/alu_carry,
// directed vectors run through a table loop, and hand-written sequences cover
// reset, tie arbitration and reset during EXEC.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        ack0, done0, carry0, err0;
  logic        ack1, done1, carry1, err1;
  logic [31:0] result0, result1;
  logic [31:0] alu_dataA, alu_dataB, alu_dataC;
  logic [3:0]  alu_control;
  logic        alu_carry;
  logic        busy, grant_id;

  int checks = 0;
  int errors = 0;
  logic bad_op_seen = 1'b0;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        e;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] mres [2];
  logic        mcar [2];
  logic        merr [2];

  always #5 clk = ~clk;

  alu_share_arbiter #(.WORD_LENGTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .ack0(ack0), .done0(done0), .result0(result0), .carry0(carry0), .err0(err0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .ack1(ack1), .done1(done1), .result1(result1), .carry1(carry1), .err1(err1),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_control(alu_control),
    .alu_dataC(alu_dataC), .alu_carry(alu_carry),
    .busy(busy), .grant_id(grant_id)
  );

  // Behavioural ALU: 0 AND, 1 OR, 2 ADD, 3 SUB (carry = borrow), 4 XOR, 5 MUL,
  // 6..10 pass A, anything else zero.
  always_comb begin
    logic [32:0] t;
    t = 33'd0;
    case (alu_control)
      4'd0:    t = {1'b0, alu_dataA & alu_dataB};
      4'd1:    t = {1'b0, alu_dataA | alu_dataB};
      4'd2:    t = {1'b0, alu_dataA} + {1'b0, alu_dataB};
      4'd3:    t = {1'b0, alu_dataA} - {1'b0, alu_dataB};
      4'd4:    t = {1'b0, alu_dataA ^ alu_dataB};
      4'd5:    t = {1'b0, alu_dataA * alu_dataB};
      4'd6, 4'd7, 4'd8, 4'd9, 4'd10: t = {1'b0, alu_dataA};
      default: t = 33'd0;
    endcase
    alu_dataC = t[31:0];
    alu_carry = t[32];
  end

  // Illegal codes must never reach the ALU.
  always @(negedge clk) begin
    if (alu_control >= 4'd11 && alu_control != 4'hF) bad_op_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_txn(input vec_t v);
    logic got;
    logic legal;
    legal = (v.op <= 4'd10);
    @(negedge clk);
    if (v.id) begin
      req1 = 1'b1; op1 = v.op; a1 = v.a; b1 = v.b;
    end else begin
      req0 = 1'b1; op0 = v.op; a0 = v.a; b0 = v.b;
    end
    #1;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if ((v.id ? ack1 : ack0) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("ack_seen", {63'd0, got}, 64'd1);
    if (!got) begin
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    chk("ack_other", {63'd0, (v.id ? ack0 : ack1)}, 64'd0);
    chk("ack_alu_idle", {60'd0, alu_control}, 64'hF);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    if (legal) begin
      chk("exec_ctrl", {59'd0, busy, alu_control}, {59'd0, 1'b1, v.op});
      chk("exec_dataA", {32'd0, alu_dataA}, {32'd0, v.a});
      chk("exec_dataB", {32'd0, alu_dataB}, {32'd0, v.b});
      chk("exec_nodone", {62'd0, done1, done0}, 64'd0);
      @(negedge clk); #1;
    end
    mres[v.id] = v.res;
    mcar[v.id] = v.c;
    merr[v.id] = v.e;
    chk("done_pulse", {62'd0, done1, done0}, v.id ? 64'd2 : 64'd1);
    chk("result0", {32'd0, result0}, {32'd0, mres[0]});
    chk("result1", {32'd0, result1}, {32'd0, mres[1]});
    chk("flags", {60'd0, carry0, err0, carry1, err1},
        {60'd0, mcar[0], merr[0], mcar[1], merr[1]});
    chk("done_state", {58'd0, grant_id, busy, alu_control}, {58'd0, v.id, 1'b1, 4'hF});
    @(negedge clk); #1;
    chk("after_done", {61'd0, done0, done1, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    logic        ack_id [4];
    int          ack_cyc [4];

    // {id, op, a, b, result, carry, err}
    tbl[0]  = '{1'b0, 4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h4, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'hC, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h3, 32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'h5, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'h3, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'hA, 32'hCAFE_0001, 32'h0000_0002, 32'hCAFE_0001, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'hB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};

    reset = 1'b0;
    req0 = 1'b1; op0 = 4'h2; a0 = 32'd2; b0 = 32'd3;
    req1 = 1'b0; op1 = 4'h0; a1 = 32'd0; b1 = 32'd0;

    // Reset held for three cycles with req0 high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_flags", {54'd0, ack0, ack1, done0, done1, carry0, carry1, err0, err1, busy, grant_id},
          64'd0);
      chk("rst_results", {result1, result0}, 64'd0);
      chk("rst_alu", {alu_dataA, alu_dataB[27:0], alu_control}, {60'd0, 4'hF});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_ack0", {62'd0, ack0, ack1}, 64'd2);
    @(negedge clk); #1;
    chk("post_rst_exec", {59'd0, busy, alu_control}, {59'd0, 1'b1, 4'h2});
    req0 = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_done", {31'd0, done0, result0}, {31'd0, 1'b1, 32'd5});

    // Tie: both requesters held high after reset; grants alternate 0,1,0.
    do_reset();
    req0 = 1'b1; op0 = 4'h3; a0 = 32'd9; b0 = 32'd4;
    req1 = 1'b1; op1 = 4'h5; a1 = 32'd3; b1 = 32'd5;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ack0 && ack1) chk("ack_exclusive", {62'd0, ack0, ack1}, 64'd0);
      if (done0 && done1) chk("done_exclusive", {62'd0, done0, done1}, 64'd0);
      if ((ack0 || ack1) && n < 4) begin
        ack_id[n]  = ack1;
        ack_cyc[n] = i;
        n++;
      end
      if (i == 2) chk("tie_res0", {31'd0, done0, result0}, {31'd0, 1'b1, 32'd5});
      if (i == 5) chk("tie_res1", {31'd0, done1, result1}, {31'd0, 1'b1, 32'd15});
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("tie_nacks", n, 64'd3);
    chk("tie_ids", {61'd0, ack_id[0], ack_id[1], ack_id[2]}, 64'b010);
    chk("tie_cycles", {ack_cyc[0][7:0], ack_cyc[1][7:0], ack_cyc[2][7:0]}, {40'd0, 8'd0, 8'd3, 8'd6});
    chk("tie_third_done", {31'd0, done0, result0}, {31'd0, 1'b1, 32'd5});
    mres[0] = 32'd5;  mcar[0] = 1'b0; merr[0] = 1'b0;
    mres[1] = 32'd15; mcar[1] = 1'b0; merr[1] = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i]);
    end

    // Reset during EXEC aborts the transaction.
    do_reset();
    req0 = 1'b1; op0 = 4'h2; a0 = 32'd2; b0 = 32'd3;
    #1;
    chk("rexec_ack", {63'd0, ack0}, 64'd1);
    @(negedge clk); #1;
    chk("rexec_busy", {59'd0, busy, alu_control}, {59'd0, 1'b1, 4'h2});
    reset = 1'b0;
    #1;
    chk("rexec_abort", {58'd0, busy, done0, alu_control}, {58'd0, 1'b0, 1'b0, 4'hF});
    req0 = 1'b0;
    @(negedge clk); #1;
    chk("rexec_hold", {30'd0, done0, busy, result0}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rexec_idle", {30'd0, done0, busy, result0}, 64'd0);
    end

    chk("alu_never_illegal", {63'd0, bad_op_seen}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares a single combinational ALU instance between two requesters with round-robin arbitration.
- Requester 0 is the main datapath; requester 1 is the branch/address unit.
- Each accepted request is latched, driven onto the ALU for one execute cycle, and its result and carry are registered back to the owning requester with a one-cycle done pulse.
- Sits between the requesters and the ALU's dataA/dataB/control/dataC/carry pins.

Parameters:
WORD_LENGTH, 32, operand and result width in bits; identical on all data ports.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  requester 0 request; held high until ack0
op0  input  4  requester 0 ALU control code
a0  input  WORD_LENGTH  requester 0 operand A
b0  input  WORD_LENGTH  requester 0 operand B
ack0  output  1  one-cycle pulse: request 0 accepted, operands latched
done0  output  1  one-cycle pulse: result0/carry0/err0 updated
result0  output  WORD_LENGTH  requester 0 last result
carry0  output  1  requester 0 last carry
err0  output  1  requester 0 last op was illegal
req1, op1, a1, b1, ack1, done1, result1, carry1, err1: as above, for requester 1
alu_dataA  output  WORD_LENGTH  operand A to ALU
alu_dataB  output  WORD_LENGTH  operand B to ALU
alu_control  output  4  control code to ALU
alu_dataC  input  WORD_LENGTH  ALU result (combinational)
alu_carry  input  1  ALU carry (combinational)
busy  output  1  high in EXEC and DONE
grant_id  output  1  requester owning the current or last transaction

Behaviour:
Reset (reset=0, asynchronous):
- State is IDLE.
- ack*, done*, carry*, err*, busy and grant_id are 0.
- result0 and result1 are 0.
- alu_dataA and alu_dataB are 0; alu_control is 4'b1111 (ALU default: zero result, zero carry).
- last_grant internal register is 1, so requester 0 wins the first tie.
- Reset mid-transaction aborts it: no done pulse, and results are not updated.

Legal ops: 4'b0000 through 4'b1010. Codes 4'b1011 through 4'b1111 are illegal.

FSM: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - If only reqN is high, grant N.
  - If both are high, grant the requester != last_grant.
  - On grant: latch opN/aN/bN into internal op/A/B registers, set grant_id=N, pulse ackN for that cycle (combinational from state and arbitration), and update last_grant=N.
  - Legal op: next state EXEC.
  - Illegal op: next state DONE, with pending result 0, pending carry 0, pending err 1.
  - No request: stay in IDLE, ALU inputs idle (0, 0, 4'b1111).
- EXEC (exactly 1 cycle):
  - alu_dataA, alu_dataB and alu_control come from the latched registers.
  - At the clock edge ending EXEC, capture alu_dataC and alu_carry, with err 0.
  - Next state DONE.
- DONE (1 cycle):
  - In the entry edge, registered resultN/carryN/errN for the granted requester are written.
  - doneN=1 for this cycle.
  - The other requester's result registers are untouched.
  - ALU inputs return to idle.
  - Next state IDLE.
- Latency, legal op: ack in cycle T, done in T+2, result valid from T+2 and held until that requester's next completion. Maximum throughput is one transaction per 3 cycles.
- Illegal-op latency: ack in T, done in T+1.
- Arbitration happens only in IDLE. Requests arriving during EXEC or DONE wait; the requester holds req and operands stable.
- A req dropped before ack is simply withdrawn, with no side effects.
- The same requester re-asserting immediately after done is granted again only if the other requester is not requesting (round-robin fairness).
- busy=1 in EXEC and DONE, 0 in IDLE.
- The arbiter does no arithmetic; width and carry rules are the ALU's. Results are stored exactly WORD_LENGTH bits wide.
- ack0 and ack1 are never high in the same cycle; likewise done0 and done1.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req0=1 -> all outputs 0, alu_control=4'b1111, no ack. After release, ack0 on the first IDLE edge.
- Single ADD: req0=1, op0=4'b0010, a0=32'hFFFF_FFFF, b0=1 -> ack0 at T, alu_control=0010 at T+1, done0 at T+2, result0=0, carry0=1, err0=0.
- Tie then alternation: req0 and req1 both held high with SUB 9-4 and MUL 3*5 -> first grant to 0 (result0=5), second to 1 (result1=15), third to 0. ack pulses alternate with 3-cycle spacing.
- Illegal op: req1=1, op1=4'b1100 -> ack1 at T, done1 at T+1, result1=0, carry1=0, err1=1; the ALU never sees op 1100.
- Isolation: complete a req0 OR (a=0x0F, b=0xF0 -> result0=0xFF), then a req1 XOR -> result0 still 0xFF after done1.
- Reset in EXEC: assert reset=0 during EXEC of a req0 ADD -> no done0, result0 stays 0, state returns to IDLE, busy=0.
